// File: rtl/difftest_commit_sequencer_if.sv
// rtl/difftest_commit_sequencer_if.sv - ROB commit group in / single-record difftest out handshake bundle
interface difftest_commit_sequencer_if #(
    parameter int NSLOT = 4,
    parameter int PW    = 128
);
    logic [NSLOT-1:0]    in_valid;
    logic [NSLOT*PW-1:0] in_payload;
    logic                in_ready;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [PW-1:0]       out_payload;
    logic [7:0]          out_index;
    logic [15:0]         out_seq;
    logic                drop_err;

    modport slave (
        input  in_valid, in_payload, flush, out_ready,
        output in_ready, out_valid, out_payload, out_index, out_seq, drop_err
    );

    modport master (
        output in_valid, in_payload, flush, out_ready,
        input  in_ready, out_valid, out_payload, out_index, out_seq, drop_err
    );
endinterface

// File: rtl/difftest_commit_sequencer.sv
// rtl/difftest_commit_sequencer.sv - compacts per-cycle commit groups into an in-order one-record-per-cycle stream
// Optional DIFFTEST_COMMIT_STATS_EN adds stat_max_occ / stat_stall_cyc outputs.
module difftest_commit_sequencer #(
    parameter int NSLOT = 4,
    parameter int DEPTH = 16,
    parameter int PW    = 128
) (
    input  logic                    clock,
    input  logic                    reset_n,
    difftest_commit_sequencer_if.slave bus
`ifdef DIFFTEST_COMMIT_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]  stat_max_occ,
    output logic [31:0]             stat_stall_cyc
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] NSLOT_P = (AW+1)'(NSLOT);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t          state, state_next;
    logic [PW+2:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, occ, free_cnt, k_cnt;
    logic [AW:0]     slot_off [NSLOT];
    logic [AW:0]     slot_sum [NSLOT];
    logic [PW+2:0]   head;
    logic [15:0]     seq_cnt;
    logic            drop_q;
    logic            any_valid, ready, accept, valid_out, pop;

    // Each valid slot lands at wr_ptr plus the number of valid slots below it.
    always_comb begin
        k_cnt = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_off[i] = k_cnt;
            slot_sum[i] = wr_ptr + k_cnt;
            if (bus.in_valid[i]) k_cnt = k_cnt + ONE;
        end
    end

    assign occ       = wr_ptr - rd_ptr;
    assign free_cnt  = DEPTH_P - occ;
    assign any_valid = |bus.in_valid;
    assign ready     = (state != FLUSH) && (free_cnt >= NSLOT_P);
    assign accept    = ready && any_valid && !bus.flush;
    assign valid_out = (occ != '0) && (state != FLUSH);
    assign pop       = valid_out && bus.out_ready;
    assign head      = mem[rd_ptr[AW-1:0]];

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid_out;
    assign bus.out_payload = valid_out ? head[PW-1:0] : '0;
    assign bus.out_index   = valid_out ? {5'b0, head[PW+2:PW]} : 8'h00;
    assign bus.out_seq     = seq_cnt;
    assign bus.drop_err    = drop_q;

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = FLUSH;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = DRAIN;
                DRAIN:   if (pop && (occ == ONE) && !accept) state_next = IDLE;
                FLUSH:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            seq_cnt <= '0;
            drop_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) wr_ptr <= wr_ptr + k_cnt;
            // The flush cycle itself may still hand out a head; the discard happens one cycle later.
            if (state == FLUSH)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + ONE;
            if (pop) seq_cnt <= seq_cnt + 16'd1;
            if (any_valid && !ready) drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NSLOT; i++) begin
            if (accept && bus.in_valid[i])
                mem[slot_sum[i][AW-1:0]] <= {3'(i), bus.in_payload[i*PW +: PW]};
        end
    end

`ifdef DIFFTEST_COMMIT_STATS_EN
    logic [AW:0] occ_next;

    always_comb begin
        occ_next = occ;
        if (state == FLUSH) begin
            occ_next = '0;
        end else begin
            if (accept) occ_next = occ_next + k_cnt;
            if (pop)    occ_next = occ_next - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_max_occ   <= '0;
            stat_stall_cyc <= '0;
        end else begin
            if (occ_next > stat_max_occ) stat_max_occ <= occ_next;
            if (any_valid && !ready && (stat_stall_cyc != 32'hFFFF_FFFF))
                stat_stall_cyc <= stat_stall_cyc + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_difftest_commit_sequencer.sv
// tb/tb_difftest_commit_sequencer.sv - scoreboard bench for difftest_commit_sequencer
module tb_difftest_commit_sequencer;
    localparam int NSLOT = 4;
    localparam int DEPTH = 16;
    localparam int PW    = 128;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic [7:0]    index;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    difftest_commit_sequencer_if #(.NSLOT(NSLOT), .PW(PW)) bus ();

`ifdef DIFFTEST_COMMIT_STATS_EN
    logic [$clog2(DEPTH):0] stat_max_occ;
    logic [31:0]            stat_stall_cyc;
`endif

    difftest_commit_sequencer #(.NSLOT(NSLOT), .DEPTH(DEPTH), .PW(PW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef DIFFTEST_COMMIT_STATS_EN
        ,
        .stat_max_occ   (stat_max_occ),
        .stat_stall_cyc (stat_stall_cyc)
`endif
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_seq  = 16'h0000;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rec(input int tag);
        return {32'(tag), 64'h0123_4567_89AB_CDEF, ~32'(tag)};
    endfunction

    // One cycle of stimulus; expected records are queued when the group is really accepted.
    task automatic drive(input logic [NSLOT-1:0] v, input int tag_base, input logic fl,
                         input logic ordy, output logic acc);
        @(posedge clock);
        #1;
        bus.in_valid  = v;
        bus.flush     = fl;
        bus.out_ready = ordy;
        for (int i = 0; i < NSLOT; i++)
            bus.in_payload[i*PW +: PW] = v[i] ? rec(tag_base + i) : '0;
        @(negedge clock);
        acc = bus.in_ready && !fl && (|v);
        if (acc)
            for (int i = 0; i < NSLOT; i++)
                if (v[i]) sb.push_back({rec(tag_base + i), 8'(i)});
        #1;
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_without_expected: got payload %0h expected no record", bus.out_payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_payload", bus.out_payload, e.payload);
                check("out_index", PW'(bus.out_index), PW'(e.index));
                check("out_seq", PW'(bus.out_seq), PW'(exp_seq));
                exp_seq = exp_seq + 16'd1;
            end
        end
    end

    task automatic wait_drain(input int budget);
        logic acc;
        int   c = 0;
        do begin
            drive('0, 0, 1'b0, 1'b1, acc);
            c++;
        end while ((sb.size() != 0 || bus.out_valid) && c < budget);
        check("drain_complete", PW'(sb.size()), PW'(0));
        check("drain_out_valid", PW'(bus.out_valid), PW'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"},   PW'(bus.out_valid), PW'(0));
        check({tag, "_in_ready"},    PW'(bus.in_ready), PW'(1));
        check({tag, "_out_payload"}, bus.out_payload, '0);
        check({tag, "_out_index"},   PW'(bus.out_index), PW'(0));
        check({tag, "_out_seq"},     PW'(bus.out_seq), PW'(0));
        check({tag, "_drop_err"},    PW'(bus.drop_err), PW'(0));
`ifdef DIFFTEST_COMMIT_STATS_EN
        check({tag, "_stat_max_occ"},   PW'(stat_max_occ), PW'(0));
        check({tag, "_stat_stall_cyc"}, PW'(stat_stall_cyc), PW'(0));
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached with %0d records pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [15:0] seq_before;
        int          tag;
        int          guard;

        bus.in_valid   = '0;
        bus.in_payload = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_reset_values("reset");

        // A,B,-,D compacted and drained on consecutive cycles right after the accept.
        drive(4'b1011, 100, 1'b0, 1'b1, acc);
        check("t2_accept", PW'(acc), PW'(1));
        for (int c = 0; c < 3; c++) begin
            drive('0, 0, 1'b0, 1'b1, acc);
            check("t2_out_valid_drain", PW'(bus.out_valid), PW'(1));
        end
        drive('0, 0, 1'b0, 1'b1, acc);
        check("t2_out_valid_after", PW'(bus.out_valid), PW'(0));
        check("t2_out_seq", PW'(bus.out_seq), PW'(3));

        // Accept+pop in one cycle, then the in_ready threshold at occ 12/13.
        drive(4'b1111, 200, 1'b0, 1'b0, acc);
        check("t4_acc0", PW'(acc), PW'(1));
        drive(4'b1111, 210, 1'b0, 1'b1, acc);
        check("t4_acc_with_pop", PW'(acc), PW'(1));
        drive(4'b1111, 220, 1'b0, 1'b0, acc);
        check("t4_acc_occ7", PW'(acc), PW'(1));
        drive(4'b0001, 230, 1'b0, 1'b0, acc);
        check("t4_acc_occ11", PW'(acc), PW'(1));
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t4_in_ready_occ12", PW'(bus.in_ready), PW'(1));
        drive(4'b0001, 240, 1'b0, 1'b0, acc);
        check("t4_acc_occ12", PW'(acc), PW'(1));
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t4_in_ready_occ13", PW'(bus.in_ready), PW'(0));
        wait_drain(40);

        // Flush at occ 5 beats a same-cycle accept.
        drive(4'b1111, 300, 1'b0, 1'b0, acc);
        drive(4'b0001, 310, 1'b0, 1'b0, acc);
        seq_before = bus.out_seq;
        drive(4'b1111, 320, 1'b1, 1'b0, acc);
        check("t5_in_ready_flush_cycle", PW'(bus.in_ready), PW'(1));
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t5_flush_out_valid", PW'(bus.out_valid), PW'(0));
        check("t5_flush_in_ready", PW'(bus.in_ready), PW'(0));
        sb.delete();
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t5_idle_out_valid", PW'(bus.out_valid), PW'(0));
        check("t5_idle_in_ready", PW'(bus.in_ready), PW'(1));
        check("t5_drop_err", PW'(bus.drop_err), PW'(0));
        check("t5_out_seq_kept", PW'(bus.out_seq), PW'(seq_before));
        drive(4'b0001, 330, 1'b0, 1'b1, acc);
        check("t5_accept_after_flush", PW'(acc), PW'(1));
        wait_drain(10);

        // Fill to 16 with the sink stalled; the fifth group is rejected.
        for (int g = 0; g < 5; g++) begin
            drive(4'b1111, 400 + g * 4, 1'b0, 1'b0, acc);
            check("t3_group_accept", PW'(acc), PW'(g < 4));
        end
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t3_drop_err", PW'(bus.drop_err), PW'(1));
        check("t3_in_ready_full", PW'(bus.in_ready), PW'(0));
        check("t3_head_held", bus.out_payload, rec(400));
`ifdef DIFFTEST_COMMIT_STATS_EN
        check("t6_stat_max_occ", PW'(stat_max_occ), PW'(16));
        check("t3_stat_stall_cyc", PW'(stat_stall_cyc), PW'(1));
`endif
        wait_drain(40);

        // Asynchronous reset in the middle of a burst.
        drive(4'b1111, 500, 1'b0, 1'b1, acc);
        drive(4'b1111, 504, 1'b0, 1'b1, acc);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("t1_async");
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        sb.delete();
        exp_seq = 16'h0000;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("t1_in_ready_release", PW'(bus.in_ready), PW'(1));
        check("t1_out_valid_release", PW'(bus.out_valid), PW'(0));

        // Stream until the sequence counter reaches 0xFFFF, then wrap it.
        tag   = 1000;
        guard = 0;
        while (exp_seq != 16'hFFFF && guard < 80000) begin
            if (sb.size() < 8) begin
                drive(4'b1111, tag, 1'b0, 1'b1, acc);
                tag += 4;
            end else begin
                drive('0, 0, 1'b0, 1'b1, acc);
            end
            guard++;
        end
        check("t6_reach_ffff_in_budget", PW'(exp_seq), PW'(16'hFFFF));
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t6_out_seq_ffff", PW'(bus.out_seq), PW'(16'hFFFF));
        drive('0, 0, 1'b0, 1'b1, acc);
        drive('0, 0, 1'b0, 1'b0, acc);
        check("t6_out_seq_wrap", PW'(bus.out_seq), PW'(0));
        check("t6_no_drop", PW'(bus.drop_err), PW'(0));
        wait_drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
